ascon_aead_stream: RTL and testbench
====================================

# ascon_aead_stream

Parametrised streaming successor to the single-byte AEAD tile: a keyed XOR/round-constant cipher with a running tag, in encrypt or decrypt mode. It has valid/ready handshakes on both data ports, a configurable key length and tag length, and on-chip tag verification in decrypt mode. It sits between the pad/IO wrapper (or a host FIFO) and downstream logic, and processes one DW-bit word per accepted beat.

## Interface
- DW, 8: data word width in bits; must be ≥ 8.
- KEY_WORDS, 2: number of key words loaded per session; must be ≥ 1.
- TAG_WORDS, 1: number of tag words, 1..8.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  session start; sampled only in IDLE.
- mode  in  1  0 = encrypt, 1 = decrypt; captured on the start cycle.
- in_data  in  DW  key word, message word or received tag word.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final message word (MSG state only).
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- out_data  out  DW  ciphertext, plaintext or tag word.
- out_valid  out  1  out_data valid; holds until out_ready.
- out_last  out  1  final output word of the session.
- out_ready  in  1  downstream accepts.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at session end.
- auth_ok  out  1  decrypt tag matched; valid from done until next start.

## Operation
- States: IDLE → KEY → MSG → TAG → FIN → IDLE.
- IDLE:
  - in_ready=0.
  - start=1: capture mode, clear S, clear the word index i, clear auth_ok, go to KEY.
  - start is ignored in every other state.
- KEY:
  - in_ready=1.
  - Each accepted word k: S ← rotl1(S) ^ k (rotl1 = rotate left by one bit, DW wide).
  - After KEY_WORDS accepts: K ← S, T ← S, go to MSG.
- MSG:
  - in_ready = !out_valid || out_ready (single output register, no skid buffer).
  - On accept of word x with index i: ks = K ^ RC[i mod 8], with RC = {04,0b,1f,14,1a,15,09,02}, zero-extended to DW.
  - Output register ← x ^ ks; i ← i+1 (wraps freely).
  - T ← rotl1(T) ^ c, where c is the ciphertext word: the output word in encrypt, x in decrypt.
  - out_last = in_last in decrypt, 0 in encrypt.
  - Accept with in_last → TAG, with j=0.
- TAG, encrypt:
  - in_ready=0.
  - When the output register is free, load tag word j = T ^ RC[j] ^ A5 (zero-extended); j ← j+1.
  - out_last=1 on j = TAG_WORDS−1.
  - Go to FIN when the last tag word is accepted downstream.
- TAG, decrypt:
  - in_ready = !out_valid || out_ready (the last plaintext word must drain first).
  - Compare each accepted word against expected word j; a sticky mismatch flag records any miss.
  - After TAG_WORDS accepts, go to FIN.
- FIN:
  - done=1 for one cycle.
  - Decrypt: auth_ok = !mismatch. Encrypt: auth_ok=0.
  - Return to IDLE next cycle.
- All arithmetic is XOR or rotate, DW wide, with no carries. RC and A5 occupy bits [7:0].

## Timing
- Reset (asynchronous assert, synchronous release) clears state, S, K, T, i, j, mismatch and the output register.
- Reset values: in_ready=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, auth_ok=0.
- Reset mid-session aborts immediately. No partial output survives.
- Latency: an input word accepted at edge n appears on out_data after edge n. With out_ready held high, throughput is one word per cycle.
- With out_ready=0, out_data/out_valid/out_last hold stable and in_ready drops in MSG.
- Encrypt: the first tag word is loaded at the edge where the last ciphertext word leaves the register. It is never earlier than one cycle after the last message accept.
- A one-word message (in_last on i=0) is legal.
- in_last in KEY is ignored.
- in_valid in IDLE or FIN is ignored.
- done asserts one cycle after the final TAG beat (encrypt: downstream accept; decrypt: input accept).
- busy deasserts in the cycle after done.

## Test plan
- Encrypt, DW=8, KEY_WORDS=2, TAG_WORDS=1:
  - Stimulus: key 10,03; message 00,FF (in_last on FF); out_ready=1.
  - Response: out 27, D7, then B4 with out_last; done pulse; auth_ok=0.
- Decrypt, same key:
  - Stimulus: input 27, D7 (in_last), then tag B4.
  - Response: out 00, FF (out_last on FF); done; auth_ok=1.
- Decrypt with tag B5: plaintext 00, FF; done; auth_ok=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after the first message accept.
  - in_ready=0 throughout, out_data=27 held stable; the stream resumes intact and the tag is still B4.
- Start pulsed during MSG is ignored. rst_n pulsed low mid-MSG: all outputs are 0 immediately, and a new session gives identical results.
- Edge cases:
  - One-word message 00 encrypts to 27.
  - Ten-word message: RC wraps, so word 8 uses RC 04.

Source files
------------

// File: rtl/ascon_aead_stream.sv
// Streaming keyed XOR/round-constant AEAD: key absorb, per-word keystream with
// a running tag, tag emission (encrypt) or on-chip tag verification (decrypt).
module ascon_aead_stream #(
  parameter int DW        = 8,
  parameter int KEY_WORDS = 2,
  parameter int TAG_WORDS = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          auth_ok
);

  localparam int KCW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, KEY, MSG, TAG, FIN} state_t;

  state_t          state, state_nx;
  logic            mode_q;
  logic [DW-1:0]   s_q, k_q, t_q;
  logic [2:0]      i_q;
  logic [3:0]      j_q;
  logic [KCW-1:0]  kcnt_q;
  logic            mismatch_q;
  logic [DW-1:0]   out_data_q;
  logic            out_valid_q, out_last_q, auth_ok_q;

  function automatic logic [7:0] rc8(input logic [2:0] idx);
    case (idx)
      3'd0:    rc8 = 8'h04;
      3'd1:    rc8 = 8'h0b;
      3'd2:    rc8 = 8'h1f;
      3'd3:    rc8 = 8'h14;
      3'd4:    rc8 = 8'h1a;
      3'd5:    rc8 = 8'h15;
      3'd6:    rc8 = 8'h09;
      default: rc8 = 8'h02;
    endcase
  endfunction

  function automatic logic [DW-1:0] rotl1(input logic [DW-1:0] v);
    rotl1 = {v[DW-2:0], v[DW-1]};
  endfunction

  logic          out_free;
  logic          key_acc, key_last, msg_acc, tag_acc, tag_load, j_last, tag_miss;
  logic [DW-1:0] s_nx, ks, ct_word, exp_tag;

  assign out_free = !out_valid_q || out_ready;
  assign key_last = (kcnt_q == KCW'(KEY_WORDS - 1));
  assign j_last   = (j_q == 4'(TAG_WORDS - 1));
  assign key_acc  = (state == KEY) && in_valid;
  assign msg_acc  = (state == MSG) && in_valid && out_free;
  assign tag_acc  = (state == TAG) && mode_q && in_valid && out_free;
  assign tag_load = (state == TAG) && !mode_q && out_free && (j_q < 4'(TAG_WORDS));

  assign s_nx     = rotl1(s_q) ^ in_data;
  assign ks       = k_q ^ DW'(rc8(i_q));
  assign ct_word  = in_data ^ ks;
  assign exp_tag  = t_q ^ DW'(rc8(j_q[2:0]) ^ 8'hA5);
  assign tag_miss = (in_data != exp_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    done     = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE: if (start) state_nx = KEY;
      KEY: begin
        in_ready = 1'b1;
        if (in_valid && key_last) state_nx = MSG;
      end
      MSG: begin
        in_ready = out_free;
        if (msg_acc && in_last) state_nx = TAG;
      end
      TAG: begin
        if (mode_q) begin
          in_ready = out_free;
          if (tag_acc && j_last) state_nx = FIN;
        end else if (out_valid_q && out_ready && out_last_q) begin
          state_nx = FIN;
        end
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: key absorb, keystream output register, running tag and verification.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= 1'b0;
      s_q         <= '0;
      k_q         <= '0;
      t_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      kcnt_q      <= '0;
      mismatch_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      auth_ok_q   <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        mode_q     <= mode;
        s_q        <= '0;
        i_q        <= '0;
        j_q        <= '0;
        kcnt_q     <= '0;
        mismatch_q <= 1'b0;
        auth_ok_q  <= 1'b0;
      end

      if (key_acc) begin
        s_q    <= s_nx;
        kcnt_q <= kcnt_q + 1'b1;
        if (key_last) begin
          k_q <= s_nx;
          t_q <= s_nx;
        end
      end

      if (msg_acc) begin
        out_data_q  <= ct_word;
        out_valid_q <= 1'b1;
        out_last_q  <= mode_q & in_last;
        i_q         <= i_q + 1'b1;
        t_q         <= rotl1(t_q) ^ (mode_q ? in_data : ct_word);
      end else if (tag_load) begin
        out_data_q  <= exp_tag;
        out_valid_q <= 1'b1;
        out_last_q  <= j_last;
        j_q         <= j_q + 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end

      if (tag_acc) begin
        j_q <= j_q + 1'b1;
        if (tag_miss) mismatch_q <= 1'b1;
        if (j_last)   auth_ok_q  <= !(mismatch_q || tag_miss);
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign auth_ok   = auth_ok_q;

endmodule

// File: tb/tb_ascon_aead_stream.sv
// Self-checking bench for ascon_aead_stream: vector table driven through a
// scoreboard queue, plus hand sequences for backpressure, start and reset.
module tb_ascon_aead_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, mode;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_data;
  logic       out_valid, out_last, out_ready;
  logic       busy, done, auth_ok;

  int checks   = 0;
  int failures = 0;

  logic [8:0] sb_q[$];

  typedef struct {
    bit              dec;
    logic [1:0][7:0] key;
    int              n;
    logic [9:0][7:0] msg;
    logic [9:0][7:0] exp;
    logic [7:0]      tag;
    bit              exp_auth;
  } vec_t;

  vec_t vecs[6];

  ascon_aead_stream #(.DW(8), .KEY_WORDS(2), .TAG_WORDS(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .done(done), .auth_ok(auth_ok)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every downstream handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_out actual=%h required=none", {out_last, out_data});
      end else begin
        checkOutput("out_word", {23'b0, out_last, out_data}, {23'b0, sb_q.pop_front()});
      end
    end
  end

  function automatic logic [7:0] rc_tb(input int idx);
    logic [7:0] tbl[8] = '{8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02};
    return tbl[idx % 8];
  endfunction

  function automatic void model_encrypt(input logic [1:0][7:0] key, input int n,
                                        input logic [9:0][7:0] msg,
                                        output logic [9:0][7:0] ct, output logic [7:0] tag);
    logic [7:0] s, k, t;
    s = 8'h00;
    for (int kk = 0; kk < 2; kk++) s = {s[6:0], s[7]} ^ key[kk];
    k  = s;
    t  = s;
    ct = '0;
    for (int ii = 0; ii < n; ii++) begin
      ct[ii] = msg[ii] ^ k ^ rc_tb(ii);
      t      = {t[6:0], t[7]} ^ ct[ii];
    end
    tag = t ^ rc_tb(0) ^ 8'hA5;
  endfunction

  // All drive tasks are entered and left just after a rising edge.
  task automatic send_word(input logic [7:0] d, input logic l);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    checkOutput("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic start_session(input bit m);
    @(posedge clk);
    #1;
    start = 1'b1;
    mode  = m;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 1'b0;
  endtask

  task automatic send_key(input logic [1:0][7:0] key);
    for (int k = 0; k < 2; k++) send_word(key[k], 1'b1);
  endtask

  task automatic finish_session(input string tag_name, input bit exp_auth);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput({tag_name, "_done"}, {31'b0, done}, 32'd1);
    checkOutput({tag_name, "_auth_ok"}, {31'b0, auth_ok}, {31'b0, exp_auth});
    checkOutput({tag_name, "_busy_at_done"}, {31'b0, busy}, 32'd1);
    checkOutput({tag_name, "_sb_empty"}, sb_q.size(), 32'd0);
    @(negedge clk);
    checkOutput({tag_name, "_done_pulse"}, {31'b0, done}, 32'd0);
    checkOutput({tag_name, "_busy_after"}, {31'b0, busy}, 32'd0);
    checkOutput({tag_name, "_auth_hold"}, {31'b0, auth_ok}, {31'b0, exp_auth});
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input string name);
    start_session(v.dec);
    send_key(v.key);
    for (int i = 0; i < v.n; i++) begin
      sb_q.push_back({v.dec && (i == v.n - 1), v.exp[i]});
      send_word(v.msg[i], i == v.n - 1);
    end
    if (v.dec) send_word(v.tag, 1'b0);
    else       sb_q.push_back({1'b1, v.tag});
    finish_session(name, v.exp_auth);
  endtask

  task automatic check_all_zero(input string name);
    checkOutput({name, "_in_ready"},  {31'b0, in_ready},  32'd0);
    checkOutput({name, "_out_data"},  {24'b0, out_data},  32'd0);
    checkOutput({name, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({name, "_out_last"},  {31'b0, out_last},  32'd0);
    checkOutput({name, "_busy"},      {31'b0, busy},      32'd0);
    checkOutput({name, "_done"},      {31'b0, done},      32'd0);
    checkOutput({name, "_auth_ok"},   {31'b0, auth_ok},   32'd0);
  endtask

  initial begin
    logic [7:0] ten_ct[10] = '{8'h27, 8'h28, 8'h3C, 8'h37, 8'h39, 8'h36, 8'h2A, 8'h21, 8'h27, 8'h28};
    vec_t rv, rd;

    for (int k = 0; k < 6; k++) begin
      vecs[k].key = {8'h03, 8'h10};
      vecs[k].msg = '0;
      vecs[k].exp = '0;
    end
    vecs[0].dec = 0; vecs[0].n = 2;
    vecs[0].msg[0] = 8'h00; vecs[0].msg[1] = 8'hFF;
    vecs[0].exp[0] = 8'h27; vecs[0].exp[1] = 8'hD7;
    vecs[0].tag = 8'hB4; vecs[0].exp_auth = 0;
    vecs[1].dec = 1; vecs[1].n = 2;
    vecs[1].msg[0] = 8'h27; vecs[1].msg[1] = 8'hD7;
    vecs[1].exp[0] = 8'h00; vecs[1].exp[1] = 8'hFF;
    vecs[1].tag = 8'hB4; vecs[1].exp_auth = 1;
    vecs[2] = vecs[1];
    vecs[2].tag = 8'hB5; vecs[2].exp_auth = 0;
    vecs[3].dec = 0; vecs[3].n = 1;
    vecs[3].exp[0] = 8'h27; vecs[3].tag = 8'hC0; vecs[3].exp_auth = 0;
    vecs[4].dec = 0; vecs[4].n = 10; vecs[4].tag = 8'h6F; vecs[4].exp_auth = 0;
    vecs[5].dec = 1; vecs[5].n = 10; vecs[5].tag = 8'h6F; vecs[5].exp_auth = 1;
    for (int i = 0; i < 10; i++) begin
      vecs[4].exp[i] = ten_ct[i];
      vecs[5].msg[i] = ten_ct[i];
    end

    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Input beats offered in IDLE must not be taken.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      checkOutput("idle_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("idle_busy", {31'b0, busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;

    for (int v = 0; v < 6; v++) applyStimulus(vecs[v], $sformatf("vec%0d", v));

    // Backpressure after the first message word.
    start_session(1'b0);
    send_key(vecs[0].key);
    sb_q.push_back({1'b0, 8'h27});
    send_word(8'h00, 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_out_data", {24'b0, out_data}, 32'h27);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    sb_q.push_back({1'b0, 8'hD7});
    send_word(8'hFF, 1'b1);
    sb_q.push_back({1'b1, 8'hB4});
    finish_session("bp", 1'b0);

    // Start pulsed mid-message, with the opposite mode, changes nothing.
    start_session(1'b0);
    send_key(vecs[0].key);
    sb_q.push_back({1'b0, 8'h27});
    send_word(8'h00, 1'b0);
    start = 1'b1;
    mode  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    mode  = 1'b0;
    sb_q.push_back({1'b0, 8'hD7});
    send_word(8'hFF, 1'b1);
    sb_q.push_back({1'b1, 8'hB4});
    finish_session("start_mid", 1'b0);

    // Reset mid-message aborts at once; the next session is unaffected.
    start_session(1'b0);
    send_key(vecs[0].key);
    send_word(8'h00, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(vecs[0], "after_reset");

    // Random round trip against the bench model.
    for (int r = 0; r < 3; r++) begin
      rv.dec = 0;
      rv.key = {8'($urandom), 8'($urandom)};
      rv.n   = int'($urandom_range(1, 10));
      rv.msg = '0;
      for (int i = 0; i < rv.n; i++) rv.msg[i] = 8'($urandom);
      model_encrypt(rv.key, rv.n, rv.msg, rv.exp, rv.tag);
      rv.exp_auth = 0;
      applyStimulus(rv, $sformatf("rnd_enc%0d", r));
      rd          = rv;
      rd.dec      = 1;
      rd.msg      = rv.exp;
      rd.exp      = rv.msg;
      rd.exp_auth = 1;
      applyStimulus(rd, $sformatf("rnd_dec%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
